// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads a 512-bit block into a 16-word
// sliding window and streams W_0..W_{NUM_ROUNDS-1} over a valid/ready handshake.
module sha256_w_sched_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] block_in,
  input  logic         abort,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         done,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  cnt;
  logic        hs;
  logic [31:0] next_word;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign hs        = w_valid && w_ready;
  assign next_word = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

  // Outputs come straight off flops: the word at the window head and the counter.
  assign w_out  = win[0];
  assign w_idx  = cnt;
  assign w_last = w_valid && (cnt == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      w_valid   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      blk_ready <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
            cnt       <= '0;
            state     <= RUN;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            blk_ready <= 1'b0;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (hs) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_word;
            cnt     <= cnt + 6'd1;
          end
          // Abort wins over a coinciding final handshake, so no done is issued.
          if (abort || (hs && w_last)) begin
            state     <= IDLE;
            cnt       <= '0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            blk_ready <= 1'b1;
            done      <= !abort;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_w_sched_ctrl.md
Name: sha256_w_sched_ctrl

Overview:
Sequencing controller for the SHA-256 message-schedule datapath. It accepts one 512-bit padded block and holds a 16-word sliding window. It streams W_0..W_{NUM_ROUNDS-1} to the compression round over a valid/ready handshake, generating each new schedule word in-place as the window slides. It sits between the block/padding source and the round pipeline, and replaces free-running write enables with counted, back-pressurable sequencing.

Parameters:
NUM_ROUNDS, 64, number of W words streamed per block; legal range 16..64.

Ports:
CLK  input  1  clock; all state changes on the rising edge
RST  input  1  asynchronous, active-high reset
blk_valid  input  1  block_in is valid
blk_ready  output  1  controller can accept a block (high only in IDLE)
block_in  input  512  padded message block; W_0 = block_in[511:480], W_15 = block_in[31:0]
abort  input  1  synchronous abort of the current block
w_valid  output  1  w_out/w_idx are valid
w_ready  input  1  round consumer accepts the word
w_out  output  32  current schedule word W_t
w_idx  output  6  round index t
w_last  output  1  high with w_valid when t == NUM_ROUNDS-1
done  output  1  one-cycle pulse after the last word is accepted
busy  output  1  high in RUN

Behaviour:
- Reset (async, RST=1): state=IDLE, window=0, cnt=0, w_valid=0, w_out=0, w_idx=0, w_last=0, done=0, busy=0, blk_ready=0 while RST is asserted, then 1 from the first edge after release.
- States: IDLE, RUN.
- IDLE: blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: win[i] <= block_in word i (i=0..15), cnt <= 0, go RUN.
  - Latency from accept to first w_valid: 1 cycle.
- RUN: blk_ready=0, busy=1, w_valid=1, w_out=win[0], w_idx=cnt, w_last=(cnt==NUM_ROUNDS-1).
  - w_out and w_idx stay stable while w_valid&&!w_ready.
- Handshake in RUN (w_valid&&w_ready):
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], computed mod 2^32 and carry discarded.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - cnt <= cnt+1.
  - Throughput: 1 word per cycle with w_ready held high. A full block takes NUM_ROUNDS cycles of RUN.
- Last word (handshake with w_last=1): go IDLE, done=1 for exactly the next cycle, cnt <= 0. blk_ready=1 in that same cycle. A new block may be accepted in the done cycle, giving back-to-back blocks with one idle bubble.
- Words W_{NUM_ROUNDS}.. are never emitted. Generation past NUM_ROUNDS-1 is harmless; the next load overwrites the window.
- abort in RUN: go IDLE next edge, no done pulse, w_valid=0 next cycle. If abort coincides with a handshake, the word counts as consumed but is discarded and no done is issued. abort in IDLE is ignored.
- blk_valid in RUN: ignored, block not consumed (blk_ready=0).
- RST mid-block: immediate return to reset values and the block is lost. The next block restarts at W_0.
- cnt is 6 bits wide and never wraps within a block, because NUM_ROUNDS<=64 terminates it.

Test Plan:
1. "abc" block (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), w_ready=1 -> W_0..W_15 echo the input; W_16=0x61626380, W_17=0x000F0000, W_63=0x12B1EDEB; w_last only at idx 63; done pulses 1 cycle after idx 63 handshake.
2. "abc" block with w_ready toggling pseudo-randomly -> identical 64-word sequence; w_out/w_idx stable during stalls; total handshakes = 64.
3. Two blocks back-to-back (blk_valid held, second = all-zero block) -> second block accepted in the done cycle; all 64 words 0x00000000; exactly two done pulses.
4. abort asserted at idx 20 -> return to IDLE, no done, blk_ready=1 the next cycle; a fresh "abc" load restarts at idx 0 with correct W_16.
5. RST pulsed mid-RUN at idx 30 (asynchronously, between edges) -> w_valid/busy drop immediately; after release, blk_ready=1 and state IDLE.
6. NUM_ROUNDS=16 build, "abc" block -> only W_0..W_15 emitted, w_last at idx 15, done follows.
